// File: rtl/vga_frame_reader.sv
// vga_frame_reader
//
// Scans a 160x120 RGB332 frame buffer out as 640x480@60 Hz VGA timing,
// repeating every stored pixel 4x4, and drives the 12-bit Nexys4 VGA port.
// A built-in 8-bar colour pattern can replace the image for bring-up.
//
// Ports
//   Clk          in   25 MHz pixel clock
//   Rst_n        in   asynchronous active-low reset
//   Data_mem     in   frame buffer read data (RGB332), valid 1 Clk after addr_out
//   Pattern_sel  in   1 = colour bars, 0 = frame buffer image
//   addr_out     out  registered frame buffer read address
//   Hsync        out  horizontal sync, active low
//   Vsync        out  vertical sync, active low
//   Rgb          out  {R[3:0], G[3:0], B[3:0]}
//   Frame_start  out  one-cycle pulse aligned with the first Rgb pixel of a frame
//
// Timing: the raster counters and addr_out describe the same position. The
// buffer answers one cycle later, and Rgb is registered one cycle after that,
// so every position flag travels through two register stages to stay aligned
// with the pixel data.

module vga_frame_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 160,
    parameter int SCALE_SH = 2,
    parameter int AW       = 15
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic [7:0]    Data_mem,
    input  logic          Pattern_sel,
    output logic [AW-1:0] addr_out,
    output logic          Hsync,
    output logic          Vsync,
    output logic [11:0]   Rgb,
    output logic          Frame_start
);

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [AW-1:0] IMG_W_A = AW'(IMG_W);
    localparam int BAR_W = H_ACTIVE / 8;

    // Raster position and address state
    logic [9:0]    hcnt_q, hcnt_d;
    logic [9:0]    vcnt_q, vcnt_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          active_next;

    // Stage 1: flags for the position currently held in the counters
    logic       act_s1_q, hs_s1_q, vs_s1_q, fs_s1_q, pat_s1_q;
    logic [2:0] bar_s1_q;

    // Stage 2: output registers
    logic        hsync_q, vsync_q, fstart_q;
    logic [11:0] rgb_q, rgb_d;

    // Combinational flags for the current counter position
    logic       act_cur, hs_cur, vs_cur, fs_cur;
    logic [2:0] bar_cur;

    function automatic logic [11:0] map_rgb332(input logic [7:0] d);
        // Replicate the top bits so full-scale codes reach 4'hF.
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = 12'hFFF;
            3'd1:    c = 12'hFF0;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'h0F0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'hF00;
            3'd6:    c = 12'h00F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    // Counter and row-base advance. row_base steps by one stored line after
    // every fourth displayed line, which replaces a (vcnt/4)*IMG_W multiply.
    always_comb begin
        hcnt_d     = hcnt_q + 10'd1;
        vcnt_d     = vcnt_q;
        row_base_d = row_base_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            if (vcnt_q == V_LAST) begin
                vcnt_d     = '0;
                row_base_d = '0;
            end else begin
                vcnt_d = vcnt_q + 10'd1;
                if ((vcnt_q < V_ACT) && (&vcnt_q[SCALE_SH-1:0])) begin
                    row_base_d = row_base_q + IMG_W_A;
                end
            end
        end
    end

    // The address is computed for the next position so that it lands in the
    // register on the same edge as the counters it belongs to.
    always_comb begin
        active_next = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
        addr_d      = '0;
        if (active_next) begin
            addr_d = row_base_d + AW'(hcnt_d >> SCALE_SH);
        end
    end

    always_comb begin
        act_cur = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hs_cur  = !((hcnt_q >= HS_START) && (hcnt_q <= HS_END));
        vs_cur  = !((vcnt_q >= VS_START) && (vcnt_q <= VS_END));
        fs_cur  = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
    end

    // Bar index = hcnt / BAR_W, done with compares instead of a divider.
    always_comb begin
        bar_cur = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (hcnt_q < 10'(BAR_W * (i + 1))) begin
                bar_cur = 3'(i);
            end
        end
    end

    always_comb begin
        rgb_d = '0;
        if (act_s1_q) begin
            if (pat_s1_q) begin
                rgb_d = bar_colour(bar_s1_q);
            end else begin
                rgb_d = map_rgb332(Data_mem);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    // Pattern_sel is captured together with the position flags, so a toggle
    // applies from exactly the pixel that was in the counters when it changed.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            act_s1_q <= 1'b0;
            hs_s1_q  <= 1'b1;
            vs_s1_q  <= 1'b1;
            fs_s1_q  <= 1'b0;
            pat_s1_q <= 1'b0;
            bar_s1_q <= '0;
        end else begin
            act_s1_q <= act_cur;
            hs_s1_q  <= hs_cur;
            vs_s1_q  <= vs_cur;
            fs_s1_q  <= fs_cur;
            pat_s1_q <= Pattern_sel;
            bar_s1_q <= bar_cur;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            fstart_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hsync_q  <= hs_s1_q;
            vsync_q  <= vs_s1_q;
            fstart_q <= fs_s1_q;
            rgb_q    <= rgb_d;
        end
    end

    assign addr_out    = addr_q;
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign Rgb         = rgb_q;
    assign Frame_start = fstart_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader. Horizontal timing is the real 800-clock line;
// the vertical timing is shortened (12 active lines, 10 front porch, 2 sync,
// 3 back porch) so several whole frames fit in a short run.

module tb_vga_frame_reader;

    localparam int H_T     = 800;
    localparam int V_ACT   = 12;
    localparam int V_T     = 27;
    localparam int FT      = H_T * V_T;
    localparam int VS_LINE = V_ACT + 10;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        Pattern_sel = 1'b0;
    logic [7:0]  const_data = 8'hE0;
    logic        use_mem = 1'b0;
    logic [7:0]  mem_q = 8'h00;
    logic [7:0]  Data_mem;
    logic [14:0] addr_out;
    logic        Hsync, Vsync, Frame_start;
    logic [11:0] Rgb;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int tgt;
    int kt;

    typedef struct {
        int          frame;
        int          h;
        int          v;
        bit          pat;
        bit          mem;
        logic [7:0]  data;
        logic [11:0] rgb;
        bit          hs;
        bit          vs;
        bit          fs;
    } vec_t;

    vec_t vq[$];

    vga_frame_reader #(
        .V_ACTIVE (V_ACT),
        .V_FP     (10),
        .V_SYNC   (2),
        .V_BP     (3)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Data_mem    (Data_mem),
        .Pattern_sel (Pattern_sel),
        .addr_out    (addr_out),
        .Hsync       (Hsync),
        .Vsync       (Vsync),
        .Rgb         (Rgb),
        .Frame_start (Frame_start)
    );

    assign Data_mem = use_mem ? mem_q : const_data;

    always #20 Clk = ~Clk;

    // Synchronous frame buffer model: byte = low address bits, one cycle late.
    always @(posedge Clk) mem_q <= addr_out[7:0];

    // Cycles since reset release; cyc == k means the counters hold position k.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_rgb(input string name, input logic [11:0] exp);
        check(name, {20'd0, Rgb}, {20'd0, exp});
    endtask

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 100000) begin
            @(negedge Clk);
            guard++;
        end
        if (cyc != target) begin
            checks++;
            errors++;
            $display("FAIL wait: reached cyc %0d, wanted %0d", cyc, target);
        end
    endtask

    task automatic add(input int f, input int h, input int v, input bit pat, input bit mem,
                       input logic [7:0] d, input logic [11:0] rgb,
                       input bit hs, input bit vs, input bit fs);
        vec_t e;
        e = '{f, h, v, pat, mem, d, rgb, hs, vs, fs};
        vq.push_back(e);
    endtask

    // Per-cycle reference for addr_out, sync, Frame_start and blanking;
    // one comparison per line summarises that line.
    int          mon_bad = 0;
    logic [31:0] mon_act, mon_exp;
    always @(negedge Clk) begin
        int k, ch, cv, dh, dv;
        logic [14:0] e_addr;
        logic e_hs, e_vs, e_fs, e_blank;
        logic [11:0] e_rgb;
        k  = cyc;
        ch = k % H_T;
        cv = (k / H_T) % V_T;
        e_addr = (ch < 640 && cv < V_ACT) ? 15'((cv / 4) * 160 + ch / 4) : 15'd0;
        if (k < 2) begin
            e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_blank = 1'b1;
        end else begin
            dh = (k - 2) % H_T;
            dv = ((k - 2) / H_T) % V_T;
            e_hs    = !(dh >= 656 && dh <= 751);
            e_vs    = !(dv >= VS_LINE && dv <= VS_LINE + 1);
            e_fs    = (dh == 0 && dv == 0);
            e_blank = !(dh < 640 && dv < V_ACT);
        end
        e_rgb = e_blank ? 12'h000 : Rgb;
        if (addr_out !== e_addr || Hsync !== e_hs || Vsync !== e_vs ||
            Frame_start !== e_fs || Rgb !== e_rgb) begin
            if (mon_bad == 0) begin
                mon_act = {2'b0, addr_out, Frame_start, Vsync, Hsync, Rgb};
                mon_exp = {2'b0, e_addr, e_fs, e_vs, e_hs, e_rgb};
            end
            mon_bad++;
        end
        if (ch == H_T - 1) begin
            checks++;
            if (mon_bad != 0) begin
                errors++;
                $display("FAIL line_monitor cyc %0d: %0d bad cycles, first got %h expected %h",
                         k, mon_bad, mon_act, mon_exp);
            end
            mon_bad = 0;
        end
    end

    initial begin
        // frame, h, v, pat, mem, data, rgb, hs, vs, fs
        add(0,   0,  0, 0, 0, 8'hE0, 12'hF00, 1, 1, 1);
        add(0, 639,  0, 0, 0, 8'hE0, 12'hF00, 1, 1, 0);
        add(0, 640,  0, 0, 0, 8'hE0, 12'h000, 1, 1, 0);
        add(0, 655,  0, 0, 0, 8'hE0, 12'h000, 1, 1, 0);
        add(0, 656,  0, 0, 0, 8'hE0, 12'h000, 0, 1, 0);
        add(0, 751,  0, 0, 0, 8'hE0, 12'h000, 0, 1, 0);
        add(0, 752,  0, 0, 0, 8'hE0, 12'h000, 1, 1, 0);
        add(0,   0,  1, 0, 0, 8'h1C, 12'h0F0, 1, 1, 0);
        add(0,   5,  1, 0, 0, 8'h03, 12'h00F, 1, 1, 0);
        add(0,  10,  1, 0, 0, 8'h92, 12'h99A, 1, 1, 0);
        add(0,  20,  1, 0, 0, 8'h6D, 12'h665, 1, 1, 0);
        add(0,   0,  2, 1, 0, 8'h00, 12'hFFF, 1, 1, 0);
        add(0,  79,  2, 1, 0, 8'h00, 12'hFFF, 1, 1, 0);
        add(0,  80,  2, 1, 0, 8'h00, 12'hFF0, 1, 1, 0);
        add(0, 159,  2, 1, 0, 8'h00, 12'hFF0, 1, 1, 0);
        add(0, 160,  2, 1, 0, 8'h00, 12'h0FF, 1, 1, 0);
        add(0, 300,  2, 1, 0, 8'h00, 12'h0F0, 1, 1, 0);
        add(0, 399,  2, 1, 0, 8'h00, 12'hF0F, 1, 1, 0);
        add(0, 400,  2, 1, 0, 8'h00, 12'hF00, 1, 1, 0);
        add(0, 559,  2, 1, 0, 8'h00, 12'h00F, 1, 1, 0);
        add(0, 560,  2, 1, 0, 8'h00, 12'h000, 1, 1, 0);
        add(0, 640,  2, 1, 0, 8'h00, 12'h000, 1, 1, 0);
        add(0,   7,  3, 0, 1, 8'h00, 12'h005, 1, 1, 0);
        add(0,   8,  3, 0, 1, 8'h00, 12'h00A, 1, 1, 0);
        add(0, 639,  3, 0, 1, 8'h00, 12'h9FF, 1, 1, 0);
        add(0,   0,  4, 0, 1, 8'h00, 12'hB00, 1, 1, 0);
        add(0,   4,  4, 0, 1, 8'h00, 12'hB05, 1, 1, 0);
        add(0, 639,  4, 0, 1, 8'h00, 12'h2FF, 1, 1, 0);
        add(0,   0,  8, 0, 1, 8'h00, 12'h400, 1, 1, 0);
        add(0, 639, 11, 0, 1, 8'h00, 12'hDFF, 1, 1, 0);
        add(0, 640, 11, 0, 1, 8'h00, 12'h000, 1, 1, 0);
        add(0,   0, 12, 0, 1, 8'h00, 12'h000, 1, 1, 0);
        add(0,   0, 22, 0, 1, 8'h00, 12'h000, 1, 0, 0);
        add(0, 700, 23, 0, 1, 8'h00, 12'h000, 0, 0, 0);
        add(0,   0, 24, 0, 1, 8'h00, 12'h000, 1, 1, 0);
        add(1,   0,  0, 0, 0, 8'hE0, 12'hF00, 1, 1, 1);

        #5 Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset_state", {2'b0, addr_out, Frame_start, Vsync, Hsync, Rgb},
              {2'b0, 15'd0, 1'b0, 1'b1, 1'b1, 12'h000});
        #1 Rst_n = 1'b1;

        foreach (vq[i]) begin
            tgt = 2 + vq[i].frame * FT + vq[i].v * H_T + vq[i].h;
            if (tgt - 4 > cyc) wait_cyc(tgt - 4);
            Pattern_sel = vq[i].pat;
            use_mem     = vq[i].mem;
            const_data  = vq[i].data;
            wait_cyc(tgt);
            check($sformatf("vec%0d", i), {17'd0, Frame_start, Vsync, Hsync, Rgb},
                  {17'd0, vq[i].fs, vq[i].vs, vq[i].hs, vq[i].rgb});
        end

        // Mid-line switch to colour bars: counters at pixel 300 of line 10.
        kt = FT + 10 * H_T + 300;
        wait_cyc(kt - 10);
        Pattern_sel = 1'b0;
        use_mem     = 1'b0;
        const_data  = 8'h92;
        wait_cyc(kt);
        Pattern_sel = 1'b1;
        wait_cyc(kt + 1);
        check_rgb("toggle_px299", 12'h99A);
        wait_cyc(kt + 2);
        check_rgb("toggle_px300", 12'h0F0);
        wait_cyc(kt + 22);
        check_rgb("toggle_px320", 12'hF0F);
        wait_cyc(kt + 182);
        check_rgb("toggle_px480", 12'h00F);

        // Reset while counters sit at (400,5) of the third frame.
        kt = 2 * FT + 5 * H_T + 400;
        wait_cyc(kt);
        check("pre_reset_addr", {17'd0, addr_out}, 32'd260);
        check_rgb("pre_reset_rgb", 12'hF0F);
        #1 Rst_n = 1'b0;
        #1;
        check("async_reset", {2'b0, addr_out, Frame_start, Vsync, Hsync, Rgb},
              {2'b0, 15'd0, 1'b0, 1'b1, 1'b1, 12'h000});
        repeat (3) @(negedge Clk);
        #1 Rst_n = 1'b1;
        wait_cyc(1);
        check("restart_fs_c1", {31'd0, Frame_start}, 32'd0);
        wait_cyc(2);
        check("restart_fs_c2", {19'd0, Frame_start, Rgb}, {19'd0, 1'b1, 12'hFFF});
        wait_cyc(3);
        check("restart_addr_c3", {17'd0, addr_out}, 32'd0);
        wait_cyc(4);
        check("restart_addr_c4", {17'd0, addr_out}, 32'd1);
        wait_cyc(900);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
